ram_burst_ctrl: RTL and testbench
=================================

RAM_BURST_CTRL -- requirements
Module: ram_burst_ctrl

Interface
REQ-001 Parameters SHALL be, one per line:
  DATA_WIDTH  8   data bits per beat
  ADDR_WIDTH  32  memory address bits
  LEN_WIDTH   4   burst length field bits; beats = cmd_len+1 (1..2^LEN_WIDTH)
REQ-002 Ports SHALL be, one per line:
  clk              in   1           single clock; all logic on posedge
  reset            in   1           synchronous, active-high reset
  cmd_valid        in   1           burst command offered
  cmd_ready        out  1           command accepted when valid&ready
  cmd_write        in   1           1 = write burst, 0 = read burst
  cmd_addr         in   ADDR_WIDTH  burst start address
  cmd_len          in   LEN_WIDTH   beats minus one
  wr_valid         in   1           write beat offered
  wr_ready         out  1           write beat consumed when valid&ready
  wr_data          in   DATA_WIDTH  write beat data
  rd_valid         out  1           read beat available
  rd_ready         in   1           read beat consumed when valid&ready
  rd_data          out  DATA_WIDTH  read beat data
  rd_last          out  1           marks final read beat of burst
  busy             out  1           high in any state other than IDLE
  mem_addr         out  ADDR_WIDTH  RAM address
  mem_dataIn       out  DATA_WIDTH  RAM write data
  mem_writeEnable  out  1           RAM write strobe
  mem_dataOut      in   DATA_WIDTH  RAM registered read data, valid one cycle after address
REQ-003 Clock and reset SHALL be clk and reset; reset SHALL be synchronous and active-high.

Function
REQ-004 States SHALL be IDLE, WRITE, READ, DRAIN; cmd_ready SHALL be high only in IDLE.
REQ-005 On command handshake: cur_addr<=cmd_addr, remaining<=cmd_len; next state WRITE if cmd_write, else READ.
REQ-006 mem_addr SHALL equal cur_addr combinationally; address increments modulo 2^ADDR_WIDTH (all-ones wraps to 0).
REQ-007 WRITE: wr_ready=1; mem_writeEnable=wr_valid; mem_dataIn=wr_data; each handshake writes one beat, increments cur_addr.
REQ-008 WRITE: handshake with remaining==0 SHALL return to IDLE next cycle; wr_valid idle cycles stall without a write.
REQ-009 wr_ready and mem_writeEnable SHALL be 0 outside WRITE; wr_valid elsewhere ignored.
REQ-010 READ: a read is issued in a cycle when (buf_count + inflight - pop) < 2, pop = rd_valid&rd_ready; issue increments cur_addr, sets inflight for next cycle.
REQ-011 Cycle after an issue, mem_dataOut SHALL be captured into a 2-entry FIFO at that clock edge; inflight clears.
REQ-012 rd_valid = FIFO non-empty; rd_data/rd_last = FIFO head; no read beat SHALL ever be dropped or duplicated.
REQ-013 After issuing with remaining==0, go to DRAIN; DRAIN issues nothing; exit to IDLE when FIFO empty and no inflight (or emptied by pop that cycle).
REQ-014 rd_last SHALL be 1 only on the beat from the final issued address.
REQ-015 Latency: command handshake in cycle 0 -> first issue cycle 1 -> rd_valid cycle 3; with rd_ready held high, throughput SHALL be one beat per cycle.
REQ-016 rd_ready low SHALL stall issue once FIFO+inflight reaches 2; resuming loses no data.
REQ-017 Back-to-back: a new command may be accepted the cycle IDLE is re-entered.

Reset
REQ-018 While reset is high at a posedge: state<=IDLE, FIFO emptied, inflight<=0, cur_addr<=0, remaining<=0.
REQ-019 During and after reset: cmd_ready=1 (after exit), wr_ready=0, rd_valid=0, rd_last=0, busy=0, mem_writeEnable=0, mem_addr=0, mem_dataIn=0.
REQ-020 Reset mid-burst SHALL abandon the burst; pending read beats are discarded; no further RAM writes occur.

Verification
REQ-021 Write burst addr=0x10, len=3, data A0..A3 every cycle -> 4 writes at 0x10..0x13, cmd_ready back at cycle 5.
REQ-022 Read burst addr=0x10, len=3, rd_ready=1 -> rd_data A0..A3 cycles 3..6, rd_last only with A3.
REQ-023 Same read with rd_ready low cycles 3..8 -> issues stop at 2 outstanding, then A0..A3 delivered in order, none lost.
REQ-024 Read addr=0xFFFFFFFE, len=3 -> addresses FFFFFFFE, FFFFFFFF, 0, 1.
REQ-025 Write len=7, wr_valid toggling 1/0 -> exactly 8 writes, mem_writeEnable only on valid cycles.
REQ-026 Reset asserted in the 3rd cycle of a read burst -> next cycle rd_valid=0, busy=0, cmd_ready=1 after release.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Burst controller between a command/stream interface and a single-port RAM
// with registered read data; reads are prefetched into a 2-entry FIFO.
module ram_burst_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_dataIn,
  output logic                  mem_writeEnable,
  input  logic [DATA_WIDTH-1:0] mem_dataOut
);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  remaining_q, remaining_d;
  logic                  inflight_q, inflight_d;
  logic                  inflight_last_q, inflight_last_d;

  logic [DATA_WIDTH-1:0] fifo_data_q [2];
  logic [1:0]            fifo_last_q;
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            count_q, count_d;

  logic pop, push, issue;

  // Occupancy accounting: a read is only issued when its beat is guaranteed a FIFO slot.
  always_comb begin
    pop     = (count_q != 2'd0) && rd_ready;
    push    = inflight_q;
    count_d = count_q + {1'b0, push} - {1'b0, pop};
    issue   = (state_q == READ) &&
              (({1'b0, count_q} + {2'b00, inflight_q}) < (3'd2 + {2'b00, pop}));
  end

  always_comb begin
    state_d         = state_q;
    cur_addr_d      = cur_addr_q;
    remaining_d     = remaining_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    cmd_ready       = 1'b0;
    wr_ready        = 1'b0;
    mem_writeEnable = 1'b0;
    mem_dataIn      = '0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          cur_addr_d  = cmd_addr;
          remaining_d = cmd_len;
          state_d     = cmd_write ? WRITE : READ;
        end
      end
      WRITE: begin
        wr_ready        = !reset;
        mem_writeEnable = wr_valid && !reset;
        mem_dataIn      = wr_data;
        if (wr_valid) begin
          cur_addr_d = cur_addr_q + ADDR_WIDTH'(1);
          if (remaining_q == '0) state_d = IDLE;
          else remaining_d = remaining_q - LEN_WIDTH'(1);
        end
      end
      READ: begin
        if (issue) begin
          cur_addr_d      = cur_addr_q + ADDR_WIDTH'(1);
          inflight_d      = 1'b1;
          inflight_last_d = (remaining_q == '0);
          if (remaining_q == '0) state_d = DRAIN;
          else remaining_d = remaining_q - LEN_WIDTH'(1);
        end
      end
      DRAIN: begin
        if (!inflight_q && count_d == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      cur_addr_q      <= '0;
      remaining_q     <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
      fifo_last_q     <= 2'b00;
      for (int i = 0; i < 2; i++) fifo_data_q[i] <= '0;
    end else begin
      state_q         <= state_d;
      cur_addr_q      <= cur_addr_d;
      remaining_q     <= remaining_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
      count_q         <= count_d;
      // RAM data for last cycle's issue is valid now; it always has a free slot.
      if (push) begin
        fifo_data_q[wr_ptr_q] <= mem_dataOut;
        fifo_last_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q              <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
    end
  end

  assign busy     = (state_q != IDLE);
  assign mem_addr = cur_addr_q;
  assign rd_valid = (count_q != 2'd0);
  assign rd_data  = fifo_data_q[rd_ptr_q];
  assign rd_last  = rd_valid && fifo_last_q[rd_ptr_q];

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Self-checking bench for ram_burst_ctrl: emulated registered RAM, a burst-level
// reference model (address/data lists), hand-timed sequences and randomized bursts.
module tb_ram_burst_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [3:0]  cmd_len;
  logic        wr_valid, wr_ready;
  logic [7:0]  wr_data;
  logic        rd_valid, rd_ready, rd_last;
  logic [7:0]  rd_data;
  logic        busy;
  logic [31:0] mem_addr;
  logic [7:0]  mem_dataIn, mem_dataOut;
  logic        mem_writeEnable;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [7:0]  d;
    logic        last;
  } beat_t;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  len;
    int          mode;
    int          expBeats;
    logic [31:0] expEndAddr;
  } vec_t;

  logic [7:0] ramArr [logic [31:0]];
  logic [7:0] refMem [logic [31:0]];
  beat_t wrLog[$], rdLog[$], expWr[$], expRd[$];
  logic [7:0] wrBuf[$];
  vec_t vecs[8];

  ram_burst_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(32), .LEN_WIDTH(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .busy(busy), .mem_addr(mem_addr), .mem_dataIn(mem_dataIn),
    .mem_writeEnable(mem_writeEnable), .mem_dataOut(mem_dataOut)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] initVal(input logic [31:0] a);
    logic [7:0] t;
    t = a[31:24];
    return a[7:0] + (t << 2) + t;
  endfunction

  function automatic logic [7:0] ramRead(input logic [31:0] a);
    return ramArr.exists(a) ? ramArr[a] : initVal(a);
  endfunction

  function automatic logic [7:0] refRead(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : initVal(a);
  endfunction

  // RAM with one-cycle registered read, read-before-write.
  always @(posedge clk) begin
    mem_dataOut <= ramRead(mem_addr);
    if (mem_writeEnable) ramArr[mem_addr] = mem_dataIn;
  end

  always @(negedge clk) begin
    if (mem_writeEnable) wrLog.push_back('{mem_addr, mem_dataIn, 1'b0});
    if (rd_valid && rd_ready) rdLog.push_back('{32'd0, rd_data, rd_last});
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic clearLogs();
    wrLog.delete(); rdLog.delete(); expWr.delete(); expRd.delete(); wrBuf.delete();
  endtask

  task automatic compareLogs(input string tag);
    checkOutput({tag, "_wr_count"}, 32'(wrLog.size()), 32'(expWr.size()));
    for (int i = 0; i < wrLog.size() && i < expWr.size(); i++) begin
      checkOutput({tag, "_wr_addr"}, wrLog[i].a, expWr[i].a);
      checkOutput({tag, "_wr_data"}, 32'(wrLog[i].d), 32'(expWr[i].d));
    end
    checkOutput({tag, "_rd_count"}, 32'(rdLog.size()), 32'(expRd.size()));
    for (int i = 0; i < rdLog.size() && i < expRd.size(); i++) begin
      checkOutput({tag, "_rd_data"}, 32'(rdLog[i].d), 32'(expRd[i].d));
      checkOutput({tag, "_rd_last"}, 32'(rdLog[i].last), 32'(expRd[i].last));
    end
  endtask

  // Expected beat lists for one burst, derived from address arithmetic and the model memory.
  task automatic buildExpected(input logic wr, input logic [31:0] addr, input logic [3:0] len);
    int n;
    logic [31:0] a;
    logic [7:0] d;
    n = int'(len) + 1;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      if (wr) begin
        d = 8'($urandom);
        wrBuf.push_back(d);
        expWr.push_back('{a, d, 1'b0});
        refMem[a] = d;
      end else begin
        expRd.push_back('{32'd0, refRead(a), (i == n - 1)});
      end
    end
  endtask

  task automatic waitIdle(input string tag);
    int cyc;
    for (cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (!busy) break;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
  endtask

  // One full burst with the given flow-control pattern (0 always, 1 toggle, 2 random).
  task automatic applyStimulus(input string tag, input logic wr, input logic [31:0] addr,
                               input logic [3:0] len, input int mode);
    int n, sent, cyc;
    logic on;
    clearLogs();
    buildExpected(wr, addr, len);
    n = int'(len) + 1;
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
    @(negedge clk);
    checkOutput({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    sent = 0;
    for (cyc = 0; cyc < 300; cyc++) begin
      on = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      if (wr) begin
        wr_valid = on && (sent < n);
        wr_data  = wr_valid ? wrBuf[sent] : 8'($urandom);
      end else begin
        rd_ready = on;
      end
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      if (!busy) break;
      @(posedge clk); #1;
    end
    checkOutput({tag, "_idle"}, 32'(busy), 32'd0);
    wr_valid = 1'b0;
    rd_ready = 1'b0;
    checkOutput({tag, "_end_addr"}, mem_addr, addr + 32'(len) + 32'd1);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_wr_ready", 32'(wr_ready), 32'd0);
    checkOutput("rst_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rst_rd_last", 32'(rd_last), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_writeEnable), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_dataIn", 32'(mem_dataIn), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Write 0x10..0x13 with A0..A3, then a read command in the very cycle IDLE returns.
    clearLogs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h10; cmd_len = 4'd3;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0; wr_valid = 1'b1; wr_data = 8'(8'hA0 + i);
      @(negedge clk);
      checkOutput("wr_we", 32'(mem_writeEnable), 32'd1);
      checkOutput("wr_addr", mem_addr, 32'h10 + 32'(i));
      checkOutput("wr_dataIn", 32'(mem_dataIn), 32'(8'hA0 + i));
      if (i == 3) checkOutput("wr_cmd_ready_c4", 32'(cmd_ready), 32'd0);
      refMem[32'h10 + 32'(i)] = 8'(8'hA0 + i);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_len = 4'd3; rd_ready = 1'b1;
    @(negedge clk);
    checkOutput("wr_cmd_ready_c5", 32'(cmd_ready), 32'd1);
    checkOutput("wr_none_after", 32'(mem_writeEnable), 32'd0);
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      @(negedge clk);
      if (c == 1) checkOutput("rd_issue_addr", mem_addr, 32'h10);
      if (c == 2) checkOutput("rd_valid_c2", 32'(rd_valid), 32'd0);
      if (c >= 3 && c <= 6) begin
        checkOutput("rd_valid_beat", 32'(rd_valid), 32'd1);
        checkOutput("rd_data_beat", 32'(rd_data), 32'(8'hA0 + c - 3));
        checkOutput("rd_last_beat", 32'(rd_last), 32'(c == 6));
      end
      if (c == 7) checkOutput("rd_busy_c7", 32'(busy), 32'd0);
    end
    rd_ready = 1'b0;

    // Same read with rd_ready low in cycles 3..8: only two addresses may be issued.
    clearLogs();
    buildExpected(1'b0, 32'h10, 4'd3);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h10; cmd_len = 4'd3; rd_ready = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      rd_ready = (c < 3);
    end
    @(negedge clk);
    checkOutput("stall_addr", mem_addr, 32'h12);
    checkOutput("stall_rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("stall_rd_data", 32'(rd_data), 32'hA0);
    @(posedge clk); #1;
    rd_ready = 1'b1;
    waitIdle("stall");
    rd_ready = 1'b0;
    compareLogs("stall");

    // Reset in the third cycle of a read burst abandons it.
    clearLogs();
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h40; cmd_len = 4'd7; rd_ready = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rstmid_we", 32'(mem_writeEnable), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("rstmid_rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("rstmid_rd_last", 32'(rd_last), 32'd0);
    checkOutput("rstmid_busy", 32'(busy), 32'd0);
    checkOutput("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
    checkOutput("rstmid_mem_addr", mem_addr, 32'd0);
    checkOutput("rstmid_writes", 32'(wrLog.size()), 32'd0);

    // Table of bursts: {write, addr, len, flow mode, expected beats, expected end address}.
    vecs[0] = '{1'b0, 32'hFFFF_FFFE, 4'd3, 0, 4, 32'h0000_0002};
    vecs[1] = '{1'b1, 32'h0000_0020, 4'd7, 1, 8, 32'h0000_0028};
    vecs[2] = '{1'b0, 32'h0000_0020, 4'd7, 0, 8, 32'h0000_0028};
    vecs[3] = '{1'b1, 32'hFFFF_FFFE, 4'd3, 0, 4, 32'h0000_0002};
    vecs[4] = '{1'b0, 32'hFFFF_FFFE, 4'd3, 2, 4, 32'h0000_0002};
    vecs[5] = '{1'b0, 32'h0000_0100, 4'd15, 2, 16, 32'h0000_0110};
    vecs[6] = '{1'b1, 32'h0000_0200, 4'd0, 2, 1, 32'h0000_0201};
    vecs[7] = '{1'b0, 32'h0000_0200, 4'd0, 1, 1, 32'h0000_0201};
    for (int v = 0; v < 8; v++) begin
      applyStimulus($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].len, vecs[v].mode);
      checkOutput($sformatf("vec%0d_beats", v),
                  32'(vecs[v].wr ? wrLog.size() : rdLog.size()), 32'(vecs[v].expBeats));
      checkOutput($sformatf("vec%0d_end", v), mem_addr, vecs[v].expEndAddr);
      compareLogs($sformatf("vec%0d", v));
    end

    // Randomized bursts, clustered so reads often cover earlier writes and the wrap point.
    for (int r = 0; r < 30; r++) begin
      logic [31:0] ra;
      ra = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7))
                                       : 32'($urandom_range(0, 63));
      applyStimulus($sformatf("rnd%0d", r), 1'($urandom_range(0, 1)), ra,
                    4'($urandom_range(0, 15)), int'($urandom_range(0, 2)));
      compareLogs($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
